// File: rtl/btc_enc_buffer.sv
// Two-bank ping-pong block buffer between the BTC bitserial source and the encoder core.
// Read latency 1 cycle (2 with BTC_ENC_BUFFER_RDAT_REG_EN); status reflects close/release the next cycle.
// No backpressure inside: the writer must honour ofulla, and the reader releases banks via irempty.
module btc_enc_buffer #(
  parameter int pWDAT_W  = 8,
  parameter int pWADDR_W = 8,
  parameter int pTAG_W   = 8
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                iwrite,
  input  logic                iwfull,
  input  logic [pWADDR_W-1:0] iwaddr,
  input  logic [pWDAT_W-1:0]  iwdat,
  input  logic [pTAG_W-1:0]   iwtag,
  output logic                ofulla,
  output logic                oemptya,
  input  logic                irempty,
  input  logic [pWADDR_W-1:0] iraddr,
  output logic                orfull,
  output logic [pWDAT_W-1:0]  ordat,
  output logic [pTAG_W-1:0]   ortag
);

  localparam int cDEPTH = 2 ** (pWADDR_W + 1);

  logic               wbank;
  logic               rbank;
  logic [1:0]         full;
  logic [1:0]         used;
  logic [pTAG_W-1:0]  tag [2];
  logic [pWDAT_W-1:0] mem [cDEPTH];
  logic [pWDAT_W-1:0] rdat;

  logic do_close;
  logic do_release;

  // A close into a still-full bank is silently dropped.
  assign do_close   = iclkena & iwrite & iwfull & ~full[wbank];
  assign do_release = iclkena & irempty & full[rbank];

  always_ff @(posedge iclk) begin
    if (ireset) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= 2'b00;
      used  <= 2'd0;
    end else begin
      // close and release can never target the same bank, so both bits update independently
      if (do_close) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
      end
      if (do_release) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
      case ({do_close, do_release})
        2'b10:   used <= used + 2'd1;
        2'b01:   used <= used - 2'd1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset && do_close) begin
      tag[wbank] <= iwtag;
    end
  end

  always_ff @(posedge iclk) begin
    if (iclkena && iwrite) begin
      mem[{wbank, iwaddr}] <= iwdat;
    end
  end

  // Read-first: a same-word write in this cycle is not visible on ordat.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      rdat <= '0;
    end else if (iclkena) begin
      rdat <= mem[{rbank, iraddr}];
    end
  end

`ifdef BTC_ENC_BUFFER_RDAT_REG_EN
  logic [pWDAT_W-1:0] rdat_q;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      rdat_q <= '0;
    end else if (iclkena) begin
      rdat_q <= rdat;
    end
  end

  assign ordat = rdat_q;
`else
  assign ordat = rdat;
`endif

  assign ofulla  = (used == 2'd2);
  assign oemptya = (used == 2'd0);
  assign orfull  = full[rbank];
  assign ortag   = tag[rbank];

endmodule

// File: tb/tb_btc_enc_buffer.sv
// Randomized bench for btc_enc_buffer: queue-of-blocks reference model plus literal spot checks.
module tb_btc_enc_buffer;

`ifdef BTC_ENC_BUFFER_RDAT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       iclk = 1'b0;
  logic       ireset, iclkena, iwrite, iwfull, irempty;
  logic [7:0] iwaddr, iwdat, iwtag, iraddr;
  logic       ofulla, oemptya, orfull;
  logic [7:0] ordat, ortag;

  btc_enc_buffer #(.pWDAT_W(8), .pWADDR_W(8), .pTAG_W(8)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iwrite(iwrite), .iwfull(iwfull), .iwaddr(iwaddr), .iwdat(iwdat), .iwtag(iwtag),
    .ofulla(ofulla), .oemptya(oemptya),
    .irempty(irempty), .iraddr(iraddr),
    .orfull(orfull), .ordat(ordat), .ortag(ortag)
  );

  always #5 iclk = ~iclk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: completed blocks form a queue of at most two, oldest is the read bank.
  typedef struct {
    logic       bank;
    logic [7:0] tag;
  } blk_t;

  blk_t       q[$];
  logic       mwb = 1'b0;
  logic [7:0] m_mem [512];
  bit         m_vld [512];
  logic [7:0] e1 = 8'h00, e2 = 8'h00;
  bit         v1 = 0, v2 = 0;

  initial begin
    for (int i = 0; i < 512; i++) m_vld[i] = 0;
  end

  always @(posedge iclk) begin
    int   ra, wa;
    bit   cl, rl;
    blk_t b;
    logic mrb;
    if (iclkena && iwrite) begin
      wa = {23'd0, mwb, iwaddr};
    end
    if (ireset) begin
      if (iclkena && iwrite) begin
        m_mem[wa] = iwdat;
        m_vld[wa] = 1;
      end
      q.delete();
      mwb = 1'b0;
      e1 = 8'h00; v1 = 1;
      e2 = 8'h00; v2 = 1;
    end else if (iclkena) begin
      mrb = (q.size() > 0) ? q[0].bank : mwb;
      ra  = {23'd0, mrb, iraddr};
      e2 = e1; v2 = v1;
      e1 = m_mem[ra]; v1 = m_vld[ra];
      if (iwrite) begin
        m_mem[wa] = iwdat;
        m_vld[wa] = 1;
      end
      cl = iwrite && iwfull && (q.size() < 2);
      rl = irempty && (q.size() > 0);
      if (rl) void'(q.pop_front());
      if (cl) begin
        b.bank = mwb;
        b.tag  = iwtag;
        q.push_back(b);
        mwb = ~mwb;
      end
    end
  end

  always @(negedge iclk) begin
    if (chk_en) begin
      chk("oemptya", {31'd0, oemptya}, {31'd0, q.size() == 0});
      chk("ofulla",  {31'd0, ofulla},  {31'd0, q.size() == 2});
      chk("orfull",  {31'd0, orfull},  {31'd0, q.size() > 0});
      if (q.size() > 0) chk("ortag", {24'd0, ortag}, {24'd0, q[0].tag});
`ifdef BTC_ENC_BUFFER_RDAT_REG_EN
      if (v2) chk("ordat", {24'd0, ordat}, {24'd0, e2});
`else
      if (v1) chk("ordat", {24'd0, ordat}, {24'd0, e1});
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iclk);
    #2;
  endtask

  task automatic idle_inputs();
    iwrite = 0; iwfull = 0; irempty = 0; iwaddr = 0; iwdat = 0; iwtag = 0;
  endtask

  // Writes words 0..n-1 with dat=addr^x; closes on the last word when close is set.
  task automatic write_block(input int n, input logic [7:0] x, input logic [7:0] t,
                             input bit close, input bit rel_last);
    for (int a = 0; a < n; a++) begin
      iwrite = 1;
      iwaddr = a[7:0];
      iwdat  = a[7:0] ^ x;
      iwtag  = t;
      iwfull = close && (a == n - 1);
      irempty = rel_last && (a == n - 1);
      tick(1);
    end
    idle_inputs();
  endtask

  task automatic read_at(input logic [7:0] a, input logic [7:0] exp, input string name);
    iraddr = a;
    tick(LAT);
    chk(name, {24'd0, ordat}, {24'd0, exp});
  endtask

  initial begin
    ireset = 1; iclkena = 1; iraddr = 0;
    idle_inputs();
    tick(2);
    ireset = 0;
    chk_en = 1;
    tick(1);

    // 1: reset state
    chk("rst_oemptya", {31'd0, oemptya}, 32'd1);
    chk("rst_ofulla",  {31'd0, ofulla},  32'd0);
    chk("rst_orfull",  {31'd0, orfull},  32'd0);
    chk("rst_ordat",   {24'd0, ordat},   32'd0);

    // 2: one full block, then sweep it back
    write_block(256, 8'hA5, 8'h3C, 1, 0);
    chk("t2_orfull",  {31'd0, orfull},  32'd1);
    chk("t2_ortag",   {24'd0, ortag},   32'h3C);
    chk("t2_oemptya", {31'd0, oemptya}, 32'd0);
    chk("t2_ofulla",  {31'd0, ofulla},  32'd0);
    for (int a = 0; a < 256; a++) begin
      iraddr = a[7:0];
      tick(1);
    end
    read_at(8'd7, 8'd7 ^ 8'hA5, "t2_rd7");

    // 3: second block fills, third close dropped
    write_block(256, 8'h33, 8'h5A, 1, 0);
    chk("t3_ofulla", {31'd0, ofulla}, 32'd1);
    iwrite = 1; iwfull = 1; iwaddr = 8'd200; iwdat = 8'hEE; iwtag = 8'h77;
    tick(1);
    idle_inputs();
    chk("t3_ofulla_hold", {31'd0, ofulla}, 32'd1);
    chk("t3_ortag", {24'd0, ortag}, 32'h3C);
    read_at(8'd10, 8'd10 ^ 8'hA5, "t3_rd10");

    // 4: release once, then close and release together
    irempty = 1;
    tick(1);
    irempty = 0;
    chk("t4_ortag_b1", {24'd0, ortag}, 32'h5A);
    write_block(256, 8'h5C, 8'h9E, 1, 1);
    chk("t4_orfull",  {31'd0, orfull},  32'd1);
    chk("t4_ortag",   {24'd0, ortag},   32'h9E);
    chk("t4_ofulla",  {31'd0, ofulla},  32'd0);
    chk("t4_oemptya", {31'd0, oemptya}, 32'd0);
    read_at(8'd20, 8'd20 ^ 8'h5C, "t4_rd20");

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      iclkena = ($urandom_range(0, 9) < 8);
      iwrite  = $urandom_range(0, 1);
      iwfull  = iwrite && ($urandom_range(0, 19) == 0);
      iwaddr  = $urandom_range(0, 255);
      iwdat   = $urandom_range(0, 255);
      iwtag   = $urandom_range(0, 255);
      irempty = ($urandom_range(0, 9) == 0);
      iraddr  = $urandom_range(0, 255);
      ireset  = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    ireset = 0; iclkena = 1;
    idle_inputs();

    // 5: release on empty ignored; reset mid-block
    ireset = 1;
    tick(1);
    ireset = 0;
    irempty = 1;
    tick(1);
    irempty = 0;
    chk("t5_oemptya_rel", {31'd0, oemptya}, 32'd1);
    write_block(100, 8'h11, 8'h22, 0, 0);
    ireset = 1;
    tick(1);
    ireset = 0;
    chk("t5_oemptya", {31'd0, oemptya}, 32'd1);
    chk("t5_orfull",  {31'd0, orfull},  32'd0);
    write_block(256, 8'h6B, 8'h11, 1, 0);
    chk("t5_ortag", {24'd0, ortag}, 32'h11);
    read_at(8'd3, 8'd3 ^ 8'h6B, "t5_rd3");

    // 6: clock enable low freezes everything
    iclkena = 0;
    iwrite = 1; iwfull = 1; irempty = 1; iwaddr = 8'd3; iwdat = 8'hFF; iwtag = 8'h99;
    iraddr = 8'd9;
    tick(3);
    chk("t6_ordat",   {24'd0, ordat},   {24'd0, 8'd3 ^ 8'h6B});
    chk("t6_orfull",  {31'd0, orfull},  32'd1);
    chk("t6_ortag",   {24'd0, ortag},   32'h11);
    chk("t6_ofulla",  {31'd0, ofulla},  32'd0);
    chk("t6_oemptya", {31'd0, oemptya}, 32'd0);
    idle_inputs();
    iclkena = 1;
    iraddr = 8'd3;
    tick(LAT);
    chk("t6_rd3_after", {24'd0, ordat}, {24'd0, 8'd3 ^ 8'h6B});
    tick(2);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
